// File: rtl/switch_cond_pkg.sv
// Shared types and 50 MHz default timing for the switch conditioner.
// Holds the per-channel debounce state encoding and default cycle counts.
package switch_cond_pkg;

  typedef enum logic [1:0] {
    STABLE0 = 2'b00,
    PEND1   = 2'b01,
    STABLE1 = 2'b10,
    PEND0   = 2'b11
  } deb_state_t;

  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
  localparam int unsigned DEF_HOLD_CYCLES     = 100_000_000;

  function automatic deb_state_t stable_of(input logic lvl);
    return lvl ? STABLE1 : STABLE0;
  endfunction

endpackage

// File: rtl/switch_debounce_conditioner_channel.sv
// One debounce channel: 2-flop sync, debounce FSM, hold counter, pulses.
// Ports: clk, reset, raw_in -> db_level, rise/fall/hold pulses.
module debounce_channel
  import switch_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter logic        RESET_LEVEL     = 1'b1,
  parameter logic        ACTIVE_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic db_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic hold_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

  localparam deb_state_t RST_STATE = stable_of(RESET_LEVEL);
  localparam deb_state_t ACT_STATE = stable_of(ACTIVE_LEVEL);

  logic sync_q1;
  logic sync_q2;

  deb_state_t    state_q;
  deb_state_t    state_d;
  logic [DW-1:0] deb_cnt_q;
  logic [DW-1:0] deb_cnt_d;
  logic [HW-1:0] hold_cnt_q;
  logic [HW-1:0] hold_cnt_d;
  logic          db_q;
  logic          db_d;
  logic          rise_q;
  logic          rise_d;
  logic          fall_q;
  logic          fall_d;
  logic          hold_q;
  logic          hold_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= RESET_LEVEL;
      sync_q2 <= RESET_LEVEL;
    end else begin
      sync_q1 <= raw_in;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RST_STATE;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      db_q       <= RESET_LEVEL;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      db_q       <= db_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    db_d       = db_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    hold_d     = 1'b0;

    unique case (state_q)
      STABLE0: begin
        if (sync_q2) begin
          state_d   = PEND1;
          deb_cnt_d = DW'(1);
        end
      end
      STABLE1: begin
        if (!sync_q2) begin
          state_d   = PEND0;
          deb_cnt_d = DW'(1);
        end
      end
      PEND1: begin
        if (!sync_q2) begin
          state_d   = STABLE0;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_MAX) begin
          state_d   = STABLE1;
          deb_cnt_d = '0;
          db_d      = 1'b1;
          rise_d    = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      PEND0: begin
        if (sync_q2) begin
          state_d   = STABLE1;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_MAX) begin
          state_d   = STABLE0;
          deb_cnt_d = '0;
          db_d      = 1'b0;
          fall_d    = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
    endcase

    // Count only while remaining in the active stable state; any
    // departure (including into PEND) clears it. Saturation stops
    // a second pulse until the level is left.
    if (state_q == ACT_STATE && state_d == ACT_STATE) begin
      if (hold_cnt_q != HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + HW'(1);
        hold_d     = (hold_cnt_q == HOLD_PRE);
      end
    end else begin
      hold_cnt_d = '0;
    end
  end

  assign db_level   = db_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign hold_pulse = hold_q;

endmodule

// File: rtl/switch_debounce_conditioner.sv
// Multi-channel switch conditioner: WIDTH debounce channels plus any_event.
// Ports: clk, reset, raw_in -> db_level, rise/fall/hold pulses, any_event.
module switch_debounce_conditioner
  import switch_cond_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter logic        RESET_LEVEL     = 1'b1,
  parameter logic        ACTIVE_LEVEL    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_level,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] hold_pulse,
  output logic             any_event
);

  logic any_q;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL),
      .ACTIVE_LEVEL    (ACTIVE_LEVEL)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .raw_in     (raw_in[i]),
      .db_level   (db_level[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .hold_pulse (hold_pulse[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |{rise_pulse, fall_pulse, hold_pulse};
    end
  end

  assign any_event = any_q;

endmodule

// File: tb/tb_switch_debounce_conditioner.sv
// Bench for switch_debounce_conditioner: directed steps plus random
// stimulus, checked against a window-based reference model.
module tb_switch_debounce_conditioner;

  localparam int D = 8;
  localparam int H = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] raw_in = 4'h0;
  logic [3:0] db_level;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] hold_pulse;
  logic       any_event;

  int checks = 0;
  int errors = 0;

  switch_debounce_conditioner #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .RESET_LEVEL     (1'b1),
    .ACTIVE_LEVEL    (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_in),
    .db_level   (db_level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .hold_pulse (hold_pulse),
    .any_event  (any_event)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last D+1 samples the
  // filter saw all disagree with it; a hold fires once H edges after the
  // active level was accepted, provided the last H+1 samples were active.
  logic [63:0] hist [4];
  logic [3:0]  q1m, q2m;
  logic [3:0]  db_m, rise_m, fall_m, hold_m;
  logic        any_m;
  int          flip_t [4];
  bit          fired [4];
  int          t = 0;

  function automatic bit all_eq(input logic [63:0] h, input int n,
                                input logic v);
    for (int i = 0; i < n; i++)
      if (h[i] !== v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rst);
    logic [3:0] prev;
    logic       seen;
    raw_in = r;
    reset  = rst;
    prev   = rise_m | fall_m | hold_m;
    rise_m = '0;
    fall_m = '0;
    hold_m = '0;
    if (rst) begin
      q1m   = 4'hf;
      q2m   = 4'hf;
      db_m  = 4'hf;
      any_m = 1'b0;
      for (int c = 0; c < 4; c++) begin
        hist[c]   = '1;
        flip_t[c] = t;
        fired[c]  = 1'b0;
      end
    end else begin
      any_m = |prev;
      for (int c = 0; c < 4; c++) begin
        seen    = q2m[c];
        hist[c] = {hist[c][62:0], seen};
        if (seen != db_m[c]) fired[c] = 1'b0;
        if (all_eq(hist[c], D + 1, ~db_m[c])) begin
          db_m[c]   = ~db_m[c];
          rise_m[c] = db_m[c];
          fall_m[c] = ~db_m[c];
          flip_t[c] = t;
        end else if (db_m[c] == 1'b0 && t - flip_t[c] >= H &&
                     all_eq(hist[c], H + 1, 1'b0) && !fired[c]) begin
          hold_m[c] = 1'b1;
          fired[c]  = 1'b1;
        end
      end
      q2m = q1m;
      q1m = r;
    end
    t++;
    @(posedge clk);
    #1;
    check("db_level", db_level, db_m);
    check("rise_pulse", rise_pulse, rise_m);
    check("fall_pulse", fall_pulse, fall_m);
    check("hold_pulse", hold_pulse, hold_m);
    check("any_event", {3'b000, any_event}, {3'b000, any_m});
  endtask

  initial begin
    int n;
    int n2;
    int cnt;
    logic [3:0] r;
    int pct;

    // Reset with all inputs low: outputs released, no pulses.
    for (int i = 0; i < 3; i++) step(4'h0, 1'b1);
    check("reset_level", db_level, 4'hf);
    n = -1;
    for (int i = 0; i < 30; i++) begin
      step(4'h0, 1'b0);
      if (fall_pulse === 4'hf && n < 0) n = i;
    end
    check("reset_exit_fall_lat", 4'(n), 4'd10);
    for (int i = 0; i < 14; i++) step(4'hf, 1'b0);
    check("released", db_level, 4'hf);

    // Clean press on channel 0.
    n = -1;
    for (int i = 0; i < 30; i++) begin
      step(4'he, 1'b0);
      if (fall_pulse[0] === 1'b1 && n < 0) n = i;
      if (n >= 0 && i == n + 1)
        check("press_any_event", {3'b000, any_event}, 4'b0001);
    end
    check("press_fall_lat", 4'(n), 4'd10);
    for (int i = 0; i < 14; i++) step(4'hf, 1'b0);

    // Bounce rejection on channel 1: 3-cycle excursions.
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(((i / 3) % 2 == 0) ? 4'hd : 4'hf, 1'b0);
      cnt += int'(fall_pulse[1]) + int'(rise_pulse[1]);
    end
    for (int i = 0; i < 14; i++) begin
      step(4'hf, 1'b0);
      cnt += int'(fall_pulse[1]) + int'(rise_pulse[1]);
    end
    check("bounce_pulses", 4'(cnt), 4'd0);
    check("bounce_level", {3'b000, db_level[1]}, 4'b0001);

    // Bounce then settle low on channel 1; last bounce edge is step 4.
    n = -1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step((i == 1 || i == 3) ? 4'hf : 4'hd, 1'b0);
      if (fall_pulse[1] === 1'b1) begin
        cnt++;
        if (n < 0) n = i;
      end
    end
    check("settle_fall_count", 4'(cnt), 4'd1);
    check("settle_fall_lat", 4'(n), 4'd14);
    for (int i = 0; i < 14; i++) step(4'hf, 1'b0);

    // Long press on channel 2, done twice.
    for (int rep = 0; rep < 2; rep++) begin
      n = -1;
      n2 = -1;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
        step(4'hb, 1'b0);
        if (fall_pulse[2] === 1'b1 && n < 0) n = i;
        if (hold_pulse[2] === 1'b1) begin
          cnt++;
          if (n2 < 0) n2 = i;
        end
      end
      check("hold_count", 4'(cnt), 4'd1);
      check("hold_delay", 8'(n2 - n), 8'd32);
      n = -1;
      for (int i = 0; i < 14; i++) begin
        step(4'hf, 1'b0);
        if (rise_pulse[2] === 1'b1 && n < 0) n = i;
      end
      check("hold_release_rise", 4'(n), 4'd10);
    end

    // Simultaneous press on channels 0 and 3.
    n = -1;
    for (int i = 0; i < 14; i++) begin
      step(4'h6, 1'b0);
      if (fall_pulse[0] === 1'b1 && n < 0) begin
        n = i;
        check("simul_fall", fall_pulse, 4'b1001);
      end
    end
    check("simul_lat", 4'(n), 4'd10);
    for (int i = 0; i < 14; i++) step(4'hf, 1'b0);

    // Reset while channel 1 is mid-debounce (count 5).
    for (int i = 0; i < 7; i++) step(4'hd, 1'b0);
    step(4'hd, 1'b1);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step(4'hf, 1'b0);
      cnt += int'(fall_pulse[1]);
    end
    check("midreset_fall", 4'(cnt), 4'd0);
    check("midreset_level", {3'b000, db_level[1]}, 4'b0001);

    // Random phase with varying bounce density and occasional resets.
    r = 4'hf;
    pct = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0: pct = 1;
          1: pct = 8;
          default: pct = 30;
        endcase
      end
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 99) < pct) r[c] = ~r[c];
      step(r, $urandom_range(0, 499) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debounce_conditioner.md
Name: switch_debounce_conditioner

Overview:
- Multi-channel conditioner for raw board switches and pushbuttons.
- Sits directly upstream of the Avalon PIO input ports: its db_level outputs drive their in_port pins.
- Synchronises asynchronous inputs and removes contact bounce with a per-channel counter FSM.
- Emits single-cycle rise, fall and long-press pulses, so the PIO edge capture sees exactly one clean transition per physical press.

Parameters:
- WIDTH, 4, number of independent channels.
- DEBOUNCE_CYCLES, 500000, cycles the synchronised input must stay stable before acceptance (10 ms at 50 MHz); legal range 2 and up.
- HOLD_CYCLES, 100000000, cycles in the active stable level before hold_pulse fires (2 s at 50 MHz); must be greater than DEBOUNCE_CYCLES.
- RESET_LEVEL, 1'b1, db_level and synchroniser value after reset (1 = released, active-low buttons).
- ACTIVE_LEVEL, 1'b0, level that counts as "pressed" for hold detection.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- raw_in  in  WIDTH  asynchronous switch/button pins.
- db_level  out  WIDTH  debounced level; feeds PIO in_port.
- rise_pulse  out  WIDTH  one-cycle pulse on accepted 0->1.
- fall_pulse  out  WIDTH  one-cycle pulse on accepted 1->0.
- hold_pulse  out  WIDTH  one-cycle pulse on reaching HOLD_CYCLES in the active level.
- any_event  out  1  registered OR of all rise, fall and hold pulses, delayed 1 cycle.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: sync flops and db_level = {WIDTH{RESET_LEVEL}}; all pulses and any_event = 0; FSM in STABLE_<RESET_LEVEL>; counters = 0.
  - Reset asserted mid-debounce or mid-hold aborts the operation.
  - No pulse is generated by reset entry or exit.
- Synchroniser: 2 flops per channel (sync_q1, sync_q2). The FSM sees only sync_q2.
- Per-channel FSM states: STABLE0, PEND1, STABLE1, PEND0.
  - STABLEx with sync_q2 != x: go to PEND(!x), deb_cnt <= 1.
  - PENDy with sync_q2 != y (bounce): return to STABLE(!y), deb_cnt <= 0. No output change, no pulse.
  - PENDy with sync_q2 == y and deb_cnt < DEBOUNCE_CYCLES: deb_cnt increments.
  - PENDy with deb_cnt == DEBOUNCE_CYCLES and sync_q2 == y: go to STABLEy, db_level <= y, and the matching rise or fall pulse is high for exactly that one cycle.
- Latency: raw_in stable from edge k means db_level changes on edge k+DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+2 clocks.
- Glitch rule: any excursion shorter than DEBOUNCE_CYCLES synchronised cycles is fully rejected. The counter restarts from 0 on every bounce.
- Hold counter:
  - Counts only while in STABLE_ACTIVE_LEVEL. hold_cnt saturates at HOLD_CYCLES.
  - hold_pulse fires once, on the cycle hold_cnt reaches HOLD_CYCLES.
  - No repeat until the channel leaves the active level.
  - Cleared on leaving STABLE_ACTIVE_LEVEL, including entry to PEND.
  - A bounce that returns to the active level restarts the hold count.
- Counter widths: $clog2(DEBOUNCE_CYCLES+1) and $clog2(HOLD_CYCLES+1); unsigned; no wrap-around is possible because both saturate.
- Channel independence: channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- any_event: high one cycle after any pulse bit is high.
- Pulse exclusivity: rise_pulse and fall_pulse are never both high on one channel. hold_pulse can coincide with neither, since HOLD_CYCLES > DEBOUNCE_CYCLES.

Decomposition:
- Shared package switch_cond_pkg holds:
  - state typedef deb_state_t {STABLE0, PEND1, STABLE1, PEND0}, 2 bits;
  - default-cycle constants for a 50 MHz clk.
- One sub-module, debounce_channel: synchroniser, FSM, deb and hold counters, and the three pulses for one bit.
- Top level generates WIDTH instances and builds any_event.

Test Plan:
(Bench parameters: WIDTH=4, DEBOUNCE_CYCLES=8, HOLD_CYCLES=32, RESET_LEVEL=1, ACTIVE_LEVEL=0.)
- Reset: assert reset 3 cycles with raw_in=4'b0000 -> db_level=4'b1111 and all pulses 0 during and after reset. fall_pulse[3:0] fires only 10 cycles after release.
- Clean press: raw_in[0] 1->0 at edge k, held -> db_level[0]=0 and fall_pulse[0]=1 on exactly edge k+10 for 1 cycle; any_event=1 on k+11.
- Bounce rejection: toggle raw_in[1] low/high every 3 cycles for 40 cycles, then high -> db_level[1] stays 1, no pulses.
- Bounce then settle: raw_in[1] bounces for 5 cycles, then low -> exactly one fall_pulse[1], 10 cycles after the last bounce edge.
- Long press: hold raw_in[2]=0 for 60 cycles -> a single hold_pulse[2] 32 cycles after fall_pulse[2], none after. Release -> rise_pulse[2]. A re-press repeats the sequence.
- Simultaneous and reset: press channels 0 and 3 on the same edge -> both fall_pulse bits in the same cycle. Assert reset while channel 1 is in PEND at deb_cnt=5 -> no pulse, db_level[1]=1.
